truth_table_scanner: RTL and testbench
======================================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 SHALL provide parameter SETTLE_CYCLES, default 3, meaning the number of cycles each stimulus vector is held before dut_out is sampled (legal 0..255).
REQ-002 SHALL provide port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL provide port start, input, 1 bit: request a scan; sampled only in IDLE.
REQ-005 SHALL provide port expected, input, 8 bits: reference truth-table code, latched when start is accepted.
REQ-006 SHALL provide port stim, output, 3 bits: {in1,in2,in3} drive to the 3-input gate under test.
REQ-007 SHALL provide port dut_out, input, 1 bit: output of the gate under test.
REQ-008 SHALL provide port busy, output, 1 bit: high in SETTLE state.
REQ-009 SHALL provide port code, output, 8 bits: measured truth-table code.
REQ-010 SHALL provide port match, output, 1 bit: code equals latched expected.
REQ-011 SHALL provide port result_valid, output, 1 bit: code/match valid.
REQ-012 SHALL provide port result_ack, input, 1 bit: consumer accepts result.

Function
REQ-013 SHALL implement three states: IDLE, SETTLE, DONE.
REQ-014 In IDLE with start=1, SHALL on the next edge: latch expected, clear code to 0, set stim=3'b000, load settle counter with SETTLE_CYCLES, enter SETTLE.
REQ-015 In SETTLE with counter nonzero, SHALL decrement counter and hold stim.
REQ-016 In SETTLE with counter zero, SHALL sample dut_out, shift it into code LSB (code <= {code[6:0],dut_out}), so input vector i lands in code bit 7-i (vector 000 is MSB).
REQ-017 After sampling vectors 000..110, SHALL increment stim by 1 and reload counter with SETTLE_CYCLES.
REQ-018 After sampling vector 111, SHALL enter DONE, set result_valid=1, set match = (final code == latched expected), return stim to 3'b000.
REQ-019 Each vector SHALL occupy exactly SETTLE_CYCLES+1 cycles; result_valid SHALL rise 8*(SETTLE_CYCLES+1) edges after the edge accepting start.
REQ-020 In DONE, code, match and result_valid SHALL hold stable until result_ack=1; on that edge result_valid clears and state returns to IDLE; code and match retain their values.
REQ-021 start asserted in SETTLE or DONE SHALL be ignored (no queueing); start and result_ack together in DONE SHALL only return to IDLE, a new start being required in IDLE.
REQ-022 result_ack outside DONE SHALL have no effect.
REQ-023 expected changes after start acceptance SHALL not affect match.
REQ-024 busy SHALL be combinationally derived from state (high only in SETTLE).

Reset
REQ-025 rst_n low SHALL immediately (asynchronously) force state IDLE, stim=000, code=0x00, match=0, result_valid=0, counter=0, latched expected=0x00.
REQ-026 Reset asserted mid-scan SHALL abort the scan with no result produced; after release the block waits for a new start.
REQ-027 Reset deassertion SHALL take effect synchronously; start on the first edge after release SHALL be accepted.

Verification
REQ-028 Gate model out=1 only for {in1,in2,in3} in {011,110,111}, SETTLE_CYCLES=3, expected=0x13, start pulse -> stim steps 000..111 every 4 cycles, result_valid after 32 edges, code=0x13, match=1.
REQ-029 Same gate, expected=0x12 -> code=0x13, match=0; result held 10 cycles without ack, then ack -> result_valid=0 next edge, state IDLE.
REQ-030 SETTLE_CYCLES=0, model out=in1 -> stim changes every cycle, result_valid after 8 edges, code=0x0F.
REQ-031 start re-pulsed during SETTLE and during DONE -> no restart, single result code unchanged; start coincident with ack -> returns IDLE, no new scan.
REQ-032 rst_n pulsed low after vector 010 sampled -> outputs reset values asynchronously, no result_valid; subsequent start with constant-1 model -> code=0xFF, match per expected.
REQ-033 Model with output delayed by 2 cycles relative to stim, SETTLE_CYCLES=3 -> code equals undelayed truth table (settle window absorbs delay).

Source files
------------

// File: rtl/truth_table_scanner.sv
// Sweeps a 3-input gate through all eight input vectors and records its truth table.
// Each vector is held SETTLE_CYCLES+1 cycles; the gate output is sampled on the last one.
//
// state  | meaning
// IDLE   | waiting for start; code/match keep the last result
// SETTLE | driving stim, counting down the settle window, sampling dut_out
// DONE   | result_valid high, holding code/match until result_ack
module truth_table_scanner #(
    parameter int unsigned SETTLE_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [7:0] expected,
    output logic [2:0] stim,
    input  logic       dut_out,
    output logic       busy,
    output logic [7:0] code,
    output logic       match,
    output logic       result_valid,
    input  logic       result_ack
);

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t     state, state_nxt;
    logic [7:0] cnt, cnt_nxt;
    logic [7:0] exp_q, exp_nxt;
    logic [2:0] stim_nxt;
    logic [7:0] code_nxt;
    logic       match_nxt;
    logic       valid_nxt;
    logic [7:0] code_shift;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= 8'd0;
            exp_q        <= 8'd0;
            stim         <= 3'b000;
            code         <= 8'd0;
            match        <= 1'b0;
            result_valid <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            exp_q        <= exp_nxt;
            stim         <= stim_nxt;
            code         <= code_nxt;
            match        <= match_nxt;
            result_valid <= valid_nxt;
        end
    end

    // Vector i ends up in code bit 7-i once all eight samples are shifted in.
    assign code_shift = {code[6:0], dut_out};

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        exp_nxt   = exp_q;
        stim_nxt  = stim;
        code_nxt  = code;
        match_nxt = match;
        valid_nxt = result_valid;
        case (state)
            IDLE: begin
                if (start) begin
                    exp_nxt   = expected;
                    code_nxt  = 8'd0;
                    stim_nxt  = 3'b000;
                    cnt_nxt   = SETTLE_LOAD;
                    state_nxt = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt != 8'd0) begin
                    cnt_nxt = cnt - 8'd1;
                end else begin
                    code_nxt = code_shift;
                    if (stim == 3'b111) begin
                        state_nxt = DONE;
                        valid_nxt = 1'b1;
                        match_nxt = (code_shift == exp_q);
                        stim_nxt  = 3'b000;
                    end else begin
                        stim_nxt = stim + 3'd1;
                        cnt_nxt  = SETTLE_LOAD;
                    end
                end
            end
            DONE: begin
                if (result_ack) begin
                    valid_nxt = 1'b0;
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign busy = (state == SETTLE);

endmodule

// File: tb/tb_truth_table_scanner.sv
// Scoreboard bench for truth_table_scanner: two instances (settle 3 and settle 0)
// driven against behavioural gate models, results checked against a queue of expectations.
module tb_truth_table_scanner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // instance with SETTLE_CYCLES=3
    logic       start3 = 1'b0, ack3 = 1'b0, out3;
    logic [7:0] exp3 = 8'h00, code3;
    logic [2:0] stim3;
    logic       busy3, match3, rv3;
    // instance with SETTLE_CYCLES=0
    logic       start0 = 1'b0, ack0 = 1'b0, out0;
    logic [7:0] exp0 = 8'h00, code0;
    logic [2:0] stim0;
    logic       busy0, match0, rv0;

    // model select: 0 = out 1 on 011/110/111, 1 = in1, 2 = constant 1, 3 = model 0 delayed 2 cycles
    int sel3 = 0;
    int sel0 = 1;
    logic [2:0] d1 = 3'b000, d2 = 3'b000;

    truth_table_scanner #(.SETTLE_CYCLES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .expected(exp3), .stim(stim3),
        .dut_out(out3), .busy(busy3), .code(code3), .match(match3),
        .result_valid(rv3), .result_ack(ack3)
    );

    truth_table_scanner #(.SETTLE_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .start(start0), .expected(exp0), .stim(stim0),
        .dut_out(out0), .busy(busy0), .code(code0), .match(match0),
        .result_valid(rv0), .result_ack(ack0)
    );

    function automatic logic gate_f(int m, logic [2:0] s);
        case (m)
            0:       return (s == 3'b011) || (s == 3'b110) || (s == 3'b111);
            1:       return s[2];
            2:       return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] model_code(int m);
        logic [7:0] c;
        logic [2:0] v;
        c = 8'h00;
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            c[7-i] = gate_f((m == 3) ? 0 : m, v);
        end
        return c;
    endfunction

    always @(posedge clk) begin
        d1 <= stim3;
        d2 <= d1;
    end

    assign out3 = (sel3 == 3) ? gate_f(0, d2) : gate_f(sel3, stim3);
    assign out0 = gate_f(sel0, stim0);

    typedef struct {
        logic [7:0] code;
        logic       match;
    } sb_item_t;
    sb_item_t sb_q[$];

    int vectors = 0;
    int miscompares = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic push_exp(int m, logic [7:0] e);
        sb_item_t it;
        it.code  = model_code(m);
        it.match = (model_code(m) == e);
        sb_q.push_back(it);
    endtask

    task automatic pop_exp(output sb_item_t it, output bit empty);
        empty = (sb_q.size() == 0);
        if (!empty) it = sb_q.pop_front();
        else begin
            it.code  = 8'hxx;
            it.match = 1'bx;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) tick;
        vectors++;
        if ({stim3, code3, match3, rv3, busy3} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_dut3: got stim=%b code=%h match=%b rv=%b busy=%b, want all 0",
                     stim3, code3, match3, rv3, busy3);
        end
        vectors++;
        if ({stim0, code0, match0, rv0, busy0} !== 14'd0) begin
            miscompares++;
            $display("FAIL reset_dut0: got stim=%b code=%h match=%b rv=%b busy=%b, want all 0",
                     stim0, code0, match0, rv0, busy0);
        end
        rst_n = 1'b1;
        tick;
    endtask

    task automatic test_basic_match;
        int n;
        bit bad, empty;
        sb_item_t e;
        sel3 = 0; exp3 = 8'h13; start3 = 1'b1;
        push_exp(0, 8'h13);
        tick;
        start3 = 1'b0;
        vectors++;
        if (busy3 !== 1'b1 || stim3 !== 3'b000) begin
            miscompares++;
            $display("FAIL basic_accept: got busy=%b stim=%b, want busy=1 stim=000", busy3, stim3);
        end
        n = 0; bad = 0;
        while (!rv3 && n < 200) begin
            tick; n++;
            if (!rv3 && stim3 !== 3'(n / 4)) bad = 1;
        end
        vectors++;
        if (n !== 32) begin
            miscompares++;
            $display("FAIL basic_latency: got %0d edges, want 32", n);
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL basic_stim_steps: got stim off schedule, want stim=n/4");
        end
        pop_exp(e, empty);
        vectors++;
        if (empty || code3 !== e.code || match3 !== e.match || stim3 !== 3'b000) begin
            miscompares++;
            $display("FAIL basic_result: got code=%h match=%b stim=%b, want code=%h match=%b stim=000",
                     code3, match3, stim3, e.code, e.match);
        end
        ack3 = 1'b1; tick; ack3 = 1'b0;
        vectors++;
        if (rv3 !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_ack: got rv=%b, want 0", rv3);
        end
    endtask

    task automatic test_mismatch_hold;
        int n;
        bit bad, empty;
        sb_item_t e;
        sel3 = 0; exp3 = 8'h12; start3 = 1'b1;
        push_exp(0, 8'h12);
        tick;
        start3 = 1'b0;
        n = 0;
        while (!rv3 && n < 200) begin tick; n++; end
        pop_exp(e, empty);
        vectors++;
        if (empty || n !== 32 || code3 !== e.code || match3 !== e.match) begin
            miscompares++;
            $display("FAIL mismatch_result: got n=%0d code=%h match=%b, want n=32 code=%h match=%b",
                     n, code3, match3, e.code, e.match);
        end
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick;
            if (rv3 !== 1'b1 || code3 !== 8'h13 || match3 !== 1'b0) bad = 1;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL mismatch_hold: got result unstable, want rv=1 code=13 match=0 held");
        end
        ack3 = 1'b1; tick; ack3 = 1'b0;
        vectors++;
        if (rv3 !== 1'b0 || busy3 !== 1'b0 || code3 !== 8'h13 || match3 !== 1'b0) begin
            miscompares++;
            $display("FAIL mismatch_ack: got rv=%b busy=%b code=%h match=%b, want 0 0 13 0",
                     rv3, busy3, code3, match3);
        end
    endtask

    task automatic test_settle0;
        int n;
        bit bad, empty;
        sb_item_t e;
        sel0 = 1; exp0 = 8'h0F; start0 = 1'b1;
        push_exp(1, 8'h0F);
        tick;
        start0 = 1'b0;
        n = 0; bad = 0;
        while (!rv0 && n < 200) begin
            tick; n++;
            if (!rv0 && stim0 !== 3'(n)) bad = 1;
        end
        vectors++;
        if (n !== 8 || bad) begin
            miscompares++;
            $display("FAIL settle0_timing: got n=%0d stim_bad=%0b, want n=8 stim_bad=0", n, bad);
        end
        pop_exp(e, empty);
        vectors++;
        if (empty || code0 !== e.code || match0 !== e.match) begin
            miscompares++;
            $display("FAIL settle0_result: got code=%h match=%b, want code=%h match=%b",
                     code0, match0, e.code, e.match);
        end
        ack0 = 1'b1; tick; ack0 = 1'b0;
    endtask

    task automatic test_start_ignored;
        int n;
        bit bad, empty;
        sb_item_t e;
        sel3 = 0; exp3 = 8'h13; start3 = 1'b1;
        push_exp(0, 8'h13);
        tick;
        start3 = 1'b0;
        n = 0;
        while (!rv3 && n < 200) begin
            tick; n++;
            start3 = (n == 5);
            ack3   = (n == 10);
            if (n == 12) exp3 = 8'h00;
        end
        start3 = 1'b0; ack3 = 1'b0;
        pop_exp(e, empty);
        vectors++;
        if (empty || n !== 32 || code3 !== e.code || match3 !== e.match) begin
            miscompares++;
            $display("FAIL ignore_settle: got n=%0d code=%h match=%b, want n=32 code=%h match=%b",
                     n, code3, match3, e.code, e.match);
        end
        start3 = 1'b1;
        repeat (3) tick;
        start3 = 1'b0;
        vectors++;
        if (rv3 !== 1'b1 || busy3 !== 1'b0 || code3 !== 8'h13) begin
            miscompares++;
            $display("FAIL ignore_done: got rv=%b busy=%b code=%h, want 1 0 13", rv3, busy3, code3);
        end
        start3 = 1'b1; ack3 = 1'b1;
        tick;
        start3 = 1'b0; ack3 = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            if (rv3 !== 1'b0 || busy3 !== 1'b0) bad = 1;
            tick;
        end
        vectors++;
        if (bad) begin
            miscompares++;
            $display("FAIL ack_with_start: got rv=%b busy=%b, want idle with no new scan", rv3, busy3);
        end
    endtask

    task automatic test_reset_mid_scan;
        int n;
        bit bad, empty;
        sb_item_t e;
        sel3 = 0; exp3 = 8'h13; start3 = 1'b1;
        push_exp(0, 8'h13);
        tick;
        start3 = 1'b0;
        repeat (12) tick;
        vectors++;
        if (stim3 !== 3'b011 || busy3 !== 1'b1) begin
            miscompares++;
            $display("FAIL abort_position: got stim=%b busy=%b, want 011 1", stim3, busy3);
        end
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({stim3, code3, match3, rv3, busy3} !== 14'd0) begin
            miscompares++;
            $display("FAIL async_reset: got stim=%b code=%h match=%b rv=%b busy=%b, want all 0",
                     stim3, code3, match3, rv3, busy3);
        end
        pop_exp(e, empty);
        bad = 0;
        repeat (3) begin
            tick;
            if (rv3 !== 1'b0) bad = 1;
        end
        sel3 = 2; exp3 = 8'hFF;
        rst_n = 1'b1; start3 = 1'b1;
        push_exp(2, 8'hFF);
        tick;
        start3 = 1'b0;
        vectors++;
        if (busy3 !== 1'b1 || bad) begin
            miscompares++;
            $display("FAIL start_after_reset: got busy=%b rv_seen=%b, want 1 0", busy3, bad);
        end
        n = 0;
        while (!rv3 && n < 200) begin tick; n++; end
        pop_exp(e, empty);
        vectors++;
        if (empty || n !== 32 || code3 !== e.code || match3 !== e.match) begin
            miscompares++;
            $display("FAIL after_reset_result: got n=%0d code=%h match=%b, want n=32 code=%h match=%b",
                     n, code3, match3, e.code, e.match);
        end
        ack3 = 1'b1; tick; ack3 = 1'b0;
    endtask

    task automatic test_back_to_back;
        int n;
        bit empty;
        sb_item_t e;
        sel3 = 2; exp3 = 8'h7F; start3 = 1'b1;
        push_exp(2, 8'h7F);
        tick;
        start3 = 1'b0;
        n = 0;
        while (!rv3 && n < 200) begin tick; n++; end
        pop_exp(e, empty);
        vectors++;
        if (empty || n !== 32 || code3 !== e.code || match3 !== e.match) begin
            miscompares++;
            $display("FAIL b2b_result: got n=%0d code=%h match=%b, want n=32 code=%h match=%b",
                     n, code3, match3, e.code, e.match);
        end
        ack3 = 1'b1; tick; ack3 = 1'b0;
    endtask

    task automatic test_delayed;
        int n;
        bit empty;
        sb_item_t e;
        sel3 = 3; exp3 = 8'h13; start3 = 1'b1;
        push_exp(3, 8'h13);
        tick;
        start3 = 1'b0;
        n = 0;
        while (!rv3 && n < 200) begin tick; n++; end
        pop_exp(e, empty);
        vectors++;
        if (empty || n !== 32 || code3 !== e.code || match3 !== e.match) begin
            miscompares++;
            $display("FAIL delayed_result: got n=%0d code=%h match=%b, want n=32 code=%h match=%b",
                     n, code3, match3, e.code, e.match);
        end
        ack3 = 1'b1; tick; ack3 = 1'b0;
    endtask

    initial begin
        test_reset;
        test_basic_match;
        test_mismatch_hold;
        test_settle0;
        test_start_ignored;
        test_reset_mid_scan;
        test_back_to_back;
        test_delayed;
        vectors++;
        if (sb_q.size() !== 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
